// File: rtl/sample_scan_sequencer.sv
// sample_scan_sequencer: periodic scan of enabled channels over the shared sample bus into the sample FIFO.
// Optional macro SCAN_TIMESTAMP_EN prefixes every FIFO word with current_time latched at scan start.
module sample_scan_sequencer #(
    parameter int NUM_CHANNELS = 16,
    parameter int CHAN_BASE    = 0,
    parameter int CMD_ADDR     = 242,
    parameter int PERIOD_W     = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_bus_en_i,
    input  logic        cmd_bus_wr_i,
    input  logic [15:0] cmd_bus_addr_i,
    input  logic [31:0] cmd_bus_data_i,
    input  logic [31:0] current_time_i,
    output logic        output_sample_o,
    output logic [7:0]  channel_select_o,
    input  logic [31:0] sample_data_i,
    input  logic        fifo_full_i,
    output logic        fifo_wr_en_o,
`ifdef SCAN_TIMESTAMP_EN
    output logic [71:0] fifo_din_o,
`else
    output logic [39:0] fifo_din_o,
`endif
    output logic        running_o,
    output logic [7:0]  overrun_count_o
);
    typedef enum logic [2:0] {IDLE, LOAD, SELECT, CAPTURE, PUSH, WAIT} state_t;
    localparam logic [7:0] BASE = 8'(CHAN_BASE);
    state_t                  state_q, state_d;
    logic [NUM_CHANNELS-1:0] shadow_q, shadow_d, active_q, active_d, srch_mask;
    logic [PERIOD_W-1:0]     period_q, period_d, cnt_q, cnt_d;
    logic                    running_q, running_d;
    logic [7:0]              overrun_q, overrun_d, sel_q, sel_d;
    logic [4:0]              idx_q, idx_d, nxt_idx;
    logic [31:0]             sample_q, sample_d, time_q, time_d;
    logic                    cmd_hit, start, stop, tick, busy, found, unused_bits;
    int                      srch_from;
    always_comb begin
        cmd_hit   = cmd_bus_en_i && cmd_bus_wr_i && cmd_bus_addr_i == 16'(CMD_ADDR);
        start     = cmd_hit && cmd_bus_data_i[31:30] == 2'b10;
        stop      = cmd_hit && cmd_bus_data_i[31:30] == 2'b11;
        tick      = running_q && cnt_q >= period_q - PERIOD_W'(1);
        busy      = state_q != IDLE && state_q != WAIT;
        // LOAD searches the freshly copied mask from bit 0; PUSH continues above the current index
        srch_mask = state_q == LOAD ? shadow_q : active_q;
        srch_from = state_q == LOAD ? 0 : int'(idx_q) + 1;
        found     = 1'b0;
        nxt_idx   = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--)
            if (srch_mask[i] && i >= srch_from) begin
                found   = 1'b1;
                nxt_idx = 5'(i);
            end
        state_d   = state_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        period_d  = period_q;
        running_d = running_q;
        idx_d     = idx_q;
        sel_d     = sel_q;
        sample_d  = sample_q;
        time_d    = time_q;
        if (cmd_hit && cmd_bus_data_i[31:30] == 2'b00)
            shadow_d = cmd_bus_data_i[NUM_CHANNELS-1:0];
        if (cmd_hit && cmd_bus_data_i[31:30] == 2'b01)
            period_d = cmd_bus_data_i[PERIOD_W-1:0] == '0 ? PERIOD_W'(1) : cmd_bus_data_i[PERIOD_W-1:0];
        cnt_d     = running_q ? (tick ? '0 : cnt_q + PERIOD_W'(1)) : cnt_q;
        overrun_d = tick && busy && overrun_q != 8'hFF ? overrun_q + 8'd1 : overrun_q;
        case (state_q)
            IDLE, WAIT: state_d = tick ? LOAD : state_q;
            LOAD: begin
                active_d = shadow_q;
                time_d   = current_time_i;
                state_d  = found ? SELECT : WAIT;
            end
            SELECT:  state_d = CAPTURE;
            CAPTURE: begin
                sample_d = sample_data_i;
                state_d  = PUSH;
            end
            PUSH:    state_d = fifo_full_i ? PUSH : (found ? SELECT : WAIT);
            default: state_d = IDLE;
        endcase
        // preloading the counter makes the first tick land on the cycle after start
        if (start) begin
            running_d = 1'b1;
            cnt_d     = period_q - PERIOD_W'(1);
        end
        if (stop) begin
            running_d = 1'b0;
            overrun_d = '0;
            state_d   = IDLE;
        end
        if (state_d == SELECT) begin
            idx_d = nxt_idx;
            sel_d = BASE + 8'(nxt_idx);
        end
        output_sample_o = state_q == SELECT;
        fifo_wr_en_o    = state_q == PUSH && !fifo_full_i && !stop;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            active_q  <= '0;
            period_q  <= PERIOD_W'(1);
            cnt_q     <= '0;
            running_q <= 1'b0;
            overrun_q <= '0;
            sel_q     <= '0;
            idx_q     <= '0;
            sample_q  <= '0;
            time_q    <= '0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
            overrun_q <= overrun_d;
            sel_q     <= sel_d;
            idx_q     <= idx_d;
            sample_q  <= sample_d;
            time_q    <= time_d;
        end
    end
`ifdef SCAN_TIMESTAMP_EN
    assign fifo_din_o = {time_q, sel_q, sample_q};
`else
    assign fifo_din_o = {sel_q, sample_q};
`endif
    assign unused_bits      = ^{current_time_i, cmd_bus_data_i, time_q};
    assign channel_select_o = sel_q;
    assign running_o        = running_q;
    assign overrun_count_o  = overrun_q;
endmodule

// File: tb/tb_sample_scan_sequencer.sv
// tb_sample_scan_sequencer: scoreboard bench for sample_scan_sequencer (timestamp scenario under SCAN_TIMESTAMP_EN).
module tb_sample_scan_sequencer;
`ifdef SCAN_TIMESTAMP_EN
    localparam int FW = 72;
    logic [31:0] ts_exp = '0;
`else
    localparam int FW = 40;
`endif
    logic          clk_i = 1'b0, rst_ni = 1'b0, cmd_bus_en_i = 1'b0, cmd_bus_wr_i = 1'b0, fifo_full_i = 1'b0;
    logic [15:0]   cmd_bus_addr_i = '0;
    logic [31:0]   cmd_bus_data_i = '0, current_time_i = '0, sample_data_i = 32'hDEAD_BEEF;
    logic          output_sample_o, fifo_wr_en_o, running_o;
    logic [7:0]    channel_select_o, overrun_count_o;
    logic [FW-1:0] fifo_din_o;
    int            tests = 0, fails = 0, cyc = 0, strobes = 0, rd = 0, t0 = 0, s0 = 0, n0 = 0;
    logic          strobe_n = 1'b0;
    logic [7:0]    ch_n = '0;
    logic [FW-1:0] exp_q[$], got_q[$];
    int            got_cyc[$];

    sample_scan_sequencer dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cmd_bus_en_i(cmd_bus_en_i), .cmd_bus_wr_i(cmd_bus_wr_i),
        .cmd_bus_addr_i(cmd_bus_addr_i), .cmd_bus_data_i(cmd_bus_data_i), .current_time_i(current_time_i),
        .output_sample_o(output_sample_o), .channel_select_o(channel_select_o), .sample_data_i(sample_data_i),
        .fifo_full_i(fifo_full_i), .fifo_wr_en_o(fifo_wr_en_o), .fifo_din_o(fifo_din_o),
        .running_o(running_o), .overrun_count_o(overrun_count_o)
    );

    function automatic logic [31:0] sample_of(input logic [7:0] ch);
        return {16'h5A3C, ~ch, ch};
    endfunction

    function automatic logic [FW-1:0] mk(input logic [7:0] ch);
`ifdef SCAN_TIMESTAMP_EN
        return {ts_exp, ch, sample_of(ch)};
`else
        return {ch, sample_of(ch)};
`endif
    endfunction

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // channel source: the strobed channel drives the bus for the following cycle, garbage otherwise
    always @(posedge clk_i) begin
        #1;
        sample_data_i = strobe_n ? sample_of(ch_n) : 32'hDEAD_BEEF;
    end

    always @(negedge clk_i) begin
        strobe_n <= output_sample_o;
        ch_n     <= channel_select_o;
        if (output_sample_o) strobes <= strobes + 1;
        if (fifo_wr_en_o) begin
            got_q.push_back(fifo_din_o);
            got_cyc.push_back(cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [29:0] arg, input logic [15:0] addr = 16'd242);
        cmd_bus_en_i   = 1'b1;
        cmd_bus_wr_i   = 1'b1;
        cmd_bus_addr_i = addr;
        cmd_bus_data_i = {op, arg};
        step(1);
        cmd_bus_en_i   = 1'b0;
        cmd_bus_wr_i   = 1'b0;
    endtask

    task automatic push(input logic [7:0] ch);
        exp_q.push_back(mk(ch));
    endtask

    task automatic test_reset;
        step(3);
        tests++;
        if ({output_sample_o, channel_select_o, fifo_wr_en_o, fifo_din_o} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got=%h want=0", {output_sample_o, channel_select_o, fifo_wr_en_o, fifo_din_o});
        end
        tests++;
        if ({running_o, overrun_count_o} !== 9'h0) begin
            fails++;
            $display("FAIL reset_status got=%h want=0", {running_o, overrun_count_o});
        end
        rst_ni = 1'b1;
        s0 = strobes;
        cmd(2'b10, 30'd0, 16'd243);
        step(5);
        tests++;
        if (running_o !== 1'b0 || strobes != s0) begin
            fails++;
            $display("FAIL wrong_addr got=%0d/%0d want=0/0", running_o, strobes - s0);
        end
    endtask

    task automatic test_basic_scan;
        cmd(2'b00, 30'h5);
        cmd(2'b01, 30'd20);
        push(8'd0);
        push(8'd2);
        s0 = strobes;
        cmd(2'b10, 30'd0);
        t0 = cyc;
        step(8);
        tests++;
        if (got_q.size() != rd + 2) begin
            fails++;
            $display("FAIL basic_count got=%0d want=2", got_q.size() - rd);
        end
        tests++;
        if (got_cyc[rd] != t0 + 4 || got_cyc[rd+1] != t0 + 7) begin
            fails++;
            $display("FAIL basic_timing got=%0d,%0d want=4,7", got_cyc[rd] - t0, got_cyc[rd+1] - t0);
        end
        while (exp_q.size() > 0) begin
            tests++;
            if (got_q[rd] !== exp_q[0]) begin
                fails++;
                $display("FAIL basic_data got=%h want=%h", got_q[rd], exp_q[0]);
            end
            void'(exp_q.pop_front());
            rd++;
        end
        rd = got_q.size();
        tests++;
        if (channel_select_o !== 8'd2 || strobes - s0 != 2) begin
            fails++;
            $display("FAIL basic_hold got=%0d/%0d want=2/2", channel_select_o, strobes - s0);
        end
        push(8'd0);
        push(8'd2);
        step(20);
        tests++;
        if (got_q.size() != rd + 2 || got_cyc[rd] != t0 + 24 || got_cyc[rd+1] != t0 + 27) begin
            fails++;
            $display("FAIL basic_repeat got=%0d@%0d want=2@24", got_q.size() - rd, got_cyc[rd] - t0);
        end
        while (exp_q.size() > 0) begin
            tests++;
            if (got_q[rd] !== exp_q[0]) begin
                fails++;
                $display("FAIL repeat_data got=%h want=%h", got_q[rd], exp_q[0]);
            end
            void'(exp_q.pop_front());
            rd++;
        end
        rd = got_q.size();
        cmd(2'b11, 30'd0);
    endtask

    task automatic test_fifo_full;
        cmd(2'b00, 30'h1);
        cmd(2'b01, 30'd100);
        push(8'd0);
        s0 = strobes;
        cmd(2'b10, 30'd0);
        t0 = cyc;
        step(3);
        fifo_full_i = 1'b1;
        step(10);
        tests++;
        if (got_q.size() != rd) begin
            fails++;
            $display("FAIL full_stall got=%0d want=0", got_q.size() - rd);
        end
        fifo_full_i = 1'b0;
        step(3);
        tests++;
        if (got_q.size() != rd + 1 || got_cyc[rd] != t0 + 13) begin
            fails++;
            $display("FAIL full_release got=%0d@%0d want=1@13", got_q.size() - rd, got_cyc[rd] - t0);
        end
        while (exp_q.size() > 0) begin
            tests++;
            if (got_q[rd] !== exp_q[0]) begin
                fails++;
                $display("FAIL full_data got=%h want=%h", got_q[rd], exp_q[0]);
            end
            void'(exp_q.pop_front());
            rd++;
        end
        rd = got_q.size();
        tests++;
        if (strobes - s0 != 1) begin
            fails++;
            $display("FAIL full_strobes got=%0d want=1", strobes - s0);
        end
        cmd(2'b11, 30'd0);
    endtask

    task automatic test_overrun;
        cmd(2'b00, 30'hFFFF);
        cmd(2'b01, 30'd10);
        for (int k = 0; k < 32; k++) push(8'(k % 16));
        cmd(2'b10, 30'd0);
        step(100);
        tests++;
        if (overrun_count_o !== 8'd8) begin
            fails++;
            $display("FAIL overrun_two_scans got=%0d want=8", overrun_count_o);
        end
        for (int j = 0; j < 70; j++) begin
            for (int k = 0; k < 16; k++) push(8'(k));
            step(50);
        end
        tests++;
        if (overrun_count_o !== 8'd255) begin
            fails++;
            $display("FAIL overrun_saturate got=%0d want=255", overrun_count_o);
        end
        tests++;
        if (got_q.size() != rd + exp_q.size()) begin
            fails++;
            $display("FAIL overrun_count got=%0d want=%0d", got_q.size() - rd, exp_q.size());
        end
        while (exp_q.size() > 0) begin
            tests++;
            if (got_q[rd] !== exp_q[0]) begin
                fails++;
                $display("FAIL overrun_data got=%h want=%h", got_q[rd], exp_q[0]);
            end
            void'(exp_q.pop_front());
            rd++;
        end
        rd = got_q.size();
        s0 = strobes;
        cmd(2'b11, 30'd0);
        tests++;
        if (running_o !== 1'b0 || overrun_count_o !== 8'd0) begin
            fails++;
            $display("FAIL stop_vs_tick got=%0d/%0d want=0/0", running_o, overrun_count_o);
        end
        step(25);
        tests++;
        if (strobes != s0 || got_q.size() != rd) begin
            fails++;
            $display("FAIL stop_quiet got=%0d/%0d want=0/0", strobes - s0, got_q.size() - rd);
        end
    endtask

    task automatic test_stop_capture;
        cmd(2'b00, 30'h5);
        cmd(2'b01, 30'd20);
        s0 = strobes;
        cmd(2'b10, 30'd0);
        step(3);
        tests++;
        if (channel_select_o !== 8'd0 || output_sample_o !== 1'b0) begin
            fails++;
            $display("FAIL capture_sel got=%0d/%0d want=0/0", channel_select_o, output_sample_o);
        end
        cmd(2'b11, 30'd0);
        tests++;
        if ({fifo_wr_en_o, running_o, output_sample_o, overrun_count_o} !== 11'h0) begin
            fails++;
            $display("FAIL stop_capture got=%h want=0", {fifo_wr_en_o, running_o, output_sample_o, overrun_count_o});
        end
        step(30);
        tests++;
        if (got_q.size() != rd || strobes - s0 != 1) begin
            fails++;
            $display("FAIL stop_dropped got=%0d/%0d want=0/1", got_q.size() - rd, strobes - s0);
        end
        push(8'd0);
        push(8'd2);
        cmd(2'b10, 30'd0);
        t0 = cyc;
        step(8);
        tests++;
        if (got_q.size() != rd + 2 || got_cyc[rd] != t0 + 4) begin
            fails++;
            $display("FAIL restart got=%0d@%0d want=2@4", got_q.size() - rd, got_cyc[rd] - t0);
        end
        while (exp_q.size() > 0) begin
            tests++;
            if (got_q[rd] !== exp_q[0]) begin
                fails++;
                $display("FAIL restart_data got=%h want=%h", got_q[rd], exp_q[0]);
            end
            void'(exp_q.pop_front());
            rd++;
        end
        rd = got_q.size();
        cmd(2'b11, 30'd0);
    endtask

    task automatic test_reset_mid_push;
        cmd(2'b00, 30'h5);
        cmd(2'b01, 30'd20);
        cmd(2'b10, 30'd0);
        step(4);
        tests++;
        if (fifo_wr_en_o !== 1'b1) begin
            fails++;
            $display("FAIL push_reached got=%0d want=1", fifo_wr_en_o);
        end
        s0 = strobes;
        n0 = got_q.size();
        rst_ni = 1'b0;
        #1;
        tests++;
        if ({output_sample_o, channel_select_o, fifo_wr_en_o, fifo_din_o, running_o, overrun_count_o} !== '0) begin
            fails++;
            $display("FAIL async_reset got=%h want=0", {output_sample_o, channel_select_o, fifo_wr_en_o, fifo_din_o, running_o, overrun_count_o});
        end
        step(2);
        rst_ni = 1'b1;
        step(40);
        tests++;
        if (got_q.size() != n0 || strobes != s0 || running_o !== 1'b0) begin
            fails++;
            $display("FAIL post_reset got=%0d/%0d/%0d want=0/0/0", got_q.size() - n0, strobes - s0, running_o);
        end
        rd = got_q.size();
    endtask

    task automatic test_period_zero;
        cmd(2'b00, 30'h0);
        cmd(2'b01, 30'd0);
        cmd(2'b10, 30'd0);
        step(10);
        tests++;
        if (overrun_count_o !== 8'd5 || got_q.size() != rd) begin
            fails++;
            $display("FAIL period_zero got=%0d/%0d want=5/0", overrun_count_o, got_q.size() - rd);
        end
        cmd(2'b11, 30'd0);
    endtask

`ifdef SCAN_TIMESTAMP_EN
    task automatic test_timestamp;
        cmd(2'b00, 30'h5);
        cmd(2'b01, 30'd100);
        ts_exp = 32'h1000;
        push(8'd0);
        push(8'd2);
        cmd(2'b10, 30'd0);
        current_time_i = 32'h1000;
        step(2);
        current_time_i = 32'h2000;
        step(6);
        tests++;
        if (got_q.size() != rd + 2) begin
            fails++;
            $display("FAIL ts_count got=%0d want=2", got_q.size() - rd);
        end
        while (exp_q.size() > 0) begin
            tests++;
            if (got_q[rd] !== exp_q[0]) begin
                fails++;
                $display("FAIL ts_data got=%h want=%h", got_q[rd], exp_q[0]);
            end
            void'(exp_q.pop_front());
            rd++;
        end
        rd = got_q.size();
        cmd(2'b11, 30'd0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic_scan();
        test_fifo_full();
        test_overrun();
        test_stop_capture();
        test_reset_mid_push();
        test_period_zero();
`ifdef SCAN_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
